// File: rtl/result_sign_pipe.sv
// result_sign_pipe: per-lane result sign-bit selector, registered behind a
// valid/ready handshake with a two-entry skid buffer so that upstream can
// be back-pressured without bubbles. Lanes share one handshake.
module result_sign_pipe #(
    parameter int LANES  = 1,
    parameter int FRAC_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W*LANES-1:0]   sign_select,
    input  logic [LANES-1:0]         operand_sign_a,
    input  logic [LANES-1:0]         operand_sign_b,
    input  logic [LANES-1:0]         result_sign,
    input  logic [FRAC_W*LANES-1:0]  result_fraction,
    input  logic [2:0]               round_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         result_31
);

    localparam logic [2:0] RM_RDN = 3'b010;

    // Select-code decoder for one lane; unlisted codes yield a positive sign.
    function automatic logic pick_sign(
        input logic [SEL_W-1:0] sel,
        input logic             a,
        input logic             b,
        input logic             r,
        input logic             int_msb,
        input logic             zrm
    );
        logic s;
        s = 1'b0;
        case (sel)
            SEL_W'(0):  s = 1'b0;
            SEL_W'(1):  s = 1'b1;
            SEL_W'(2):  s = a;
            SEL_W'(3):  s = b;
            SEL_W'(4):  s = ~b;
            SEL_W'(5):  s = a & b;
            SEL_W'(6):  s = a & ~b;
            SEL_W'(7):  s = r;
            SEL_W'(8):  s = int_msb;
            SEL_W'(9):  s = a ^ b;
            SEL_W'(10): s = a | b;
            SEL_W'(11): s = zrm;
            default:    s = 1'b0;
        endcase
        return s;
    endfunction

    // Only the integer-sign bit of each fraction feeds the decoder.
    logic unused_frac_bits;
    assign unused_frac_bits = ^result_fraction;

    logic             zrm;
    logic [LANES-1:0] in_data;

    assign zrm = (round_mode == RM_RDN);

    // Combinational per-lane sign selection ahead of the output register.
    always_comb begin
        in_data = '0;
        for (int i = 0; i < LANES; i++) begin
            in_data[i] = pick_sign(sign_select[i*SEL_W +: SEL_W],
                                   operand_sign_a[i],
                                   operand_sign_b[i],
                                   result_sign[i],
                                   result_fraction[i*FRAC_W + FRAC_W - 1],
                                   zrm);
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [LANES-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [LANES-1:0] skid_data_q,  skid_data_d;
    logic             accept;
    logic             drain;

    // in_ready depends only on registered skid state, never on out_ready.
    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign result_31 = out_data_q;

    // Next-state for main and skid registers; flush overrides any transfer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // Older skid entry moves up first to keep FIFO order.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (accept) begin
            // Main is stalled: park the new entry in the skid slot.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_result_sign_pipe.sv
// Self-checking bench for result_sign_pipe with LANES=2: a depth-2 FIFO
// model predicts handshake and data, checked every falling edge, plus
// directed literal checks for the documented scenarios.
module tb_result_sign_pipe;

    localparam int LANES  = 2;
    localparam int FRAC_W = 32;
    localparam int SEL_W  = 4;

    logic                    clk;
    logic                    reset_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W*LANES-1:0]  sign_select;
    logic [LANES-1:0]        operand_sign_a;
    logic [LANES-1:0]        operand_sign_b;
    logic [LANES-1:0]        result_sign;
    logic [FRAC_W*LANES-1:0] result_fraction;
    logic [2:0]              round_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES-1:0]        result_31;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [LANES-1:0] model_q[$];

    result_sign_pipe #(.LANES(LANES), .FRAC_W(FRAC_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_select(sign_select), .operand_sign_a(operand_sign_a),
        .operand_sign_b(operand_sign_b), .result_sign(result_sign),
        .result_fraction(result_fraction), .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready), .result_31(result_31)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Spec truth table as a lookup vector indexed by select code.
    function automatic logic ref_sign(input int sel, input logic a, input logic b,
                                      input logic r, input logic msb, input logic [2:0] rm);
        logic [15:0] tbl;
        tbl     = '0;
        tbl[1]  = 1'b1;
        tbl[2]  = a;
        tbl[3]  = b;
        tbl[4]  = !b;
        tbl[5]  = a && b;
        tbl[6]  = a && !b;
        tbl[7]  = r;
        tbl[8]  = msb;
        tbl[9]  = (a != b);
        tbl[10] = a || b;
        tbl[11] = (rm == 3'd2);
        return tbl[sel];
    endfunction

    function automatic logic [LANES-1:0] expected_now();
        logic [LANES-1:0] e;
        for (int i = 0; i < LANES; i++)
            e[i] = ref_sign(int'(sign_select[i*SEL_W +: SEL_W]), operand_sign_a[i],
                            operand_sign_b[i], result_sign[i],
                            result_fraction[i*FRAC_W + FRAC_W - 1], round_mode);
        return e;
    endfunction

    // Reference model: a FIFO of capacity two.
    always @(posedge clk) begin
        if (reset_n) begin
            if (flush) begin
                model_q.delete();
            end else begin
                logic acc, drn;
                logic [LANES-1:0] e;
                acc = in_valid && (model_q.size() < 2);
                drn = (model_q.size() > 0) && out_ready;
                e   = expected_now();
                if (drn) void'(model_q.pop_front());
                if (acc) model_q.push_back(e);
            end
        end
    end

    always @(negedge reset_n) model_q.delete();

    // Compare process.
    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() > 0});
        if (model_q.size() > 0)
            chk("result_31", {30'b0, result_31}, {30'b0, model_q[0]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [1:0] a, input logic [1:0] b, input logic [1:0] r,
                          input logic [31:0] f0, input logic [31:0] f1, input logic [2:0] rm);
        in_valid        = v;
        sign_select     = {s1, s0};
        operand_sign_a  = a;
        operand_sign_b  = b;
        result_sign     = r;
        result_fraction = {f1, f0};
        round_mode      = rm;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", {30'b0, result_31}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Model pins.
        chk("ref_xor", {31'b0, ref_sign(9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0)}, 32'd1);
        chk("ref_nb", {31'b0, ref_sign(4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0)}, 32'd0);
        chk("ref_zrm", {31'b0, ref_sign(11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2)}, 32'd1);

        // Lane0 A_XOR_B (a=1,b=0), lane1 IRESULT with MSB set.
        set_in(1'b1, 4'd9, 4'd8, 2'b01, 2'b00, 2'b00, 32'h0, 32'h8000_0000, 3'd0);
        step();
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_result", {30'b0, result_31}, 32'b11);
        // ZRM with RDN, then with RNE; code 13.
        set_in(1'b1, 4'd11, 4'd11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'b010);
        step();
        chk("zrm_rdn", {30'b0, result_31}, 32'b11);
        set_in(1'b1, 4'd11, 4'd13, 2'b11, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000);
        step();
        chk("zrm_rne_sel13", {30'b0, result_31}, 32'b00);

        // Every code against every (a,b) pair; lanes carry different pairs.
        for (int s = 0; s < 16; s++) begin
            for (int ab = 0; ab < 4; ab++) begin
                set_in(1'b1, 4'(s), 4'(s), {ab[1], ab[0]}, {ab[0], ab[1]},
                       2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)));
                step();
            end
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: V0=11, V1=00, V2=01.
        out_ready = 1'b0;
        set_in(1'b1, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        step();
        set_in(1'b1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        step();
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        set_in(1'b1, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        step();
        chk("bp_hold_v0", {30'b0, result_31}, 32'b11);
        // Stall hold with changing inputs.
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom));
            step();
            chk("stall_hold", {30'b0, result_31}, 32'b11);
        end
        set_in(1'b1, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        out_ready = 1'b1;
        step();
        chk("bp_v1", {30'b0, result_31}, 32'b00);
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_v2", {30'b0, result_31}, 32'b01);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush with main and skid both full and a same-cycle input.
        out_ready = 1'b0;
        set_in(1'b1, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_result", {30'b0, result_31}, 32'd0);
        out_ready = 1'b1;
        set_in(1'b1, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        step();
        chk("post_flush_val", {30'b0, result_31}, 32'b01);
        in_valid = 1'b0;
        step();
        chk("post_flush_alone", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset between edges mid-stream.
        set_in(1'b1, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0);
        out_ready = 1'b0;
        step(); step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_result", {30'b0, result_31}, 32'd0);
        #8;
        reset_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("arst_ready", {31'b0, in_ready}, 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            set_in(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                   $urandom, $urandom, 3'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_sign_pipe.md
Name: result_sign_pipe

Overview:
- Pipelined, multi-lane successor to the combinational result-sign selector. Per lane, it picks the sign bit (bit 31 / MSB) of the packed result from an extended select code.
- Adds XOR, OR and rounding-mode-aware zero-sign modes.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the result-selector stage can be back-pressured by the writeback stage without bubbles.

Parameters:
- LANES, 1, number of independent sign lanes processed per transfer (≥1).
- FRAC_W, 32, width of each lane's result_fraction; the integer-sign bit is bit FRAC_W-1.
- SEL_W, 4, width of each lane's sign_select code.

Ports:
- clk  input  1  clock, rising-edge
- reset_n  input  1  asynchronous reset, active-low
- flush  input  1  synchronous; drops all buffered entries
- in_valid  input  1  upstream presents a transfer
- in_ready  output  1  block can accept a transfer this cycle
- sign_select  input  SEL_W*LANES  per-lane select code, lane i at [i*SEL_W +: SEL_W]
- operand_sign_a  input  LANES  sign of operand A per lane
- operand_sign_b  input  LANES  sign of operand B per lane
- result_sign  input  LANES  computed sign from the datapath per lane
- result_fraction  input  FRAC_W*LANES  per-lane fraction, 2 integer bits
- round_mode  input  3  shared rounding mode; 3'b010 = RDN (round down)
- out_valid  output  1  registered result is available
- out_ready  input  1  downstream accepts the result this cycle
- result_31  output  LANES  selected sign per lane

Behaviour:
- Select codes (per lane, combinational before the register):
  - 0 ZERO → 0
  - 1 ONE → 1
  - 2 A → a
  - 3 B → b
  - 4 NB → ~b
  - 5 A_B → a&b
  - 6 A_NB → a&~b
  - 7 RESULT → result_sign
  - 8 IRESULT → result_fraction[FRAC_W-1]
  - 9 A_XOR_B → a^b
  - 10 A_OR_B → a|b
  - 11 ZRM → (round_mode==3'b010)
  - 12–15 → 0
- Storage: main register (out_valid, result_31) plus skid register (skid_valid, skid_data).
- in_ready = ~skid_valid. It is a register output only, with no combinational path from out_ready.
- Accept: an input is accepted when in_valid & in_ready.
- Drain: the output is consumed when out_valid & out_ready.
- Per-clock update:
  - Main empty or consumed, skid empty: accepted input → main. out_valid = accepted.
  - Main empty or consumed, skid full: skid → main, skid_valid → 0. The input is not accepted, because in_ready was 0.
  - Main full and not consumed: accepted input → skid, skid_valid → 1.
- Latency: 1 cycle from accept to out_valid when there is no back-pressure. Full throughput is 1 transfer/cycle.
- Ordering: strictly FIFO. The skid entry always drains before any newer entry.
- While out_valid=1 and out_ready=0, result_31 is held stable.
- flush has priority over all transfers: out_valid → 0, skid_valid → 0, result_31 → 0. An input presented in the same cycle is discarded.
- Reset (async, reset_n=0): out_valid=0, skid_valid=0, result_31=0, in_ready=1. Reset mid-stream discards all data.
- Lanes are independent; a single valid/ready pair covers all lanes.
- round_mode is sampled with the transfer (at accept), not at output.

Test Plan:
- LANES=2, out_ready=1. Lane0 sel=9 with a=1, b=0; lane1 sel=8 with fraction=32'h8000_0000. Accept at cycle 0 → at cycle 1, out_valid=1 and result_31=2'b11.
- sel=11, round_mode=3'b010 → 1. Same with round_mode=3'b000 → 0. sel=13 → 0. Codes 0–10 each checked against the truth table for all four (a,b) pairs.
- Back-pressure: stream values V0,V1,V2 with out_ready=0 from cycle 1.
  - V0 lands in main, V1 in skid; in_ready=0 at cycle 2 and V2 is held.
  - Raise out_ready → the output order is exactly V0,V1,V2 with no drop or duplicate, and in_ready returns to 1 one cycle after the skid drains.
- Stall hold: out_valid=1, out_ready=0, with inputs changing for 5 cycles → result_31 stays constant.
- flush asserted with main and skid both full, and in_valid=1 in the same cycle → next cycle out_valid=0 and in_ready=1; the next accepted value appears alone.
- reset_n pulsed low asynchronously mid-stream (between clock edges) → out_valid=0 and result_31=0 immediately; in_ready=1 after release.
